inst_buffer: RTL and testbench
==============================

# inst_buffer

Dual-ported instruction queue between the fetch stage and the decode stage. Accepts up to two fetched instructions (pc, inst, fetch exception) per cycle and presents the two oldest to the decoders (1RI20, 2RI12, 3R, etc.), which consume zero, one or two per cycle. Decouples fetch stalls from decode/issue stalls and is cleared on pipeline flush (branch mispredict, exception, ertn).

## Interface
- DEPTH, 8, number of entries; power of two, at least 4
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  clear all entries this cycle
- enq_valid  in  2  fetch slot valids; bit1 meaningful only with bit0
- enq_pc0 / enq_pc1  in  32 each  slot pc
- enq_inst0 / enq_inst1  in  32 each  slot instruction word
- enq_excp0 / enq_excp1  in  1 each  fetch exception flag (ADEF, TLB refill, PIF...)
- enq_cause0 / enq_cause1  in  7 each  exception cause code
- enq_ready  out  1  at least two free entries
- deq_valid  out  2  bit0: ≥1 entry held; bit1: ≥2 entries held
- deq_pc0 / deq_pc1, deq_inst0 / deq_inst1, deq_excp0 / deq_excp1, deq_cause0 / deq_cause1  out  32/32/1/7  entries at head and head+1
- deq_accept  in  2  decode consumes slot0 / slots 0 and 1
- count  out  PTR_W+1  entries currently held

## Operation
- Circular storage of DEPTH entries {pc, inst, excp, cause}; head, tail (PTR_W bits, wrap DEPTH-1→0) and count registers.
- Effective enqueue number n_enq = enq_ready & enq_valid[0] ? (1 + enq_valid[1]) : 0. enq_valid=2'b10 → n_enq=0, nothing written.
- Slot0 written at tail, slot1 at tail+1 (mod DEPTH); tail += n_enq.
- Effective dequeue n_deq = deq_accept[0]&deq_valid[0] ? (1 + (deq_accept[1]&deq_valid[1])) : 0. Accept bits for non-valid slots, or accept[1] without accept[0], are masked off.
- head += n_deq; count_next = count + n_enq − n_deq.
- enq_ready = (DEPTH − count ≥ 2), computed from current count only (no credit for same-cycle dequeue).
- Outputs are combinational reads of storage at head and head+1 (mod DEPTH); data fields are don't-care when corresponding deq_valid bit is 0 but must be the stored value (0 after reset).
- Entries are dequeued strictly in program order; slot1 never leaves without slot0.
- flush: head, tail, count ← 0; n_enq and n_deq forced to 0 that cycle (flush dominates enqueue and dequeue). Storage contents need not be cleared.
- No bypass: an empty queue never forwards enq_* to deq_*.

## Timing
- Reset (rst_n low, asynchronous): head=tail=count=0, all storage 0 → deq_valid=2'b00, enq_ready=1, all deq_* data 0, count=0. Held until rst_n rises; first enqueue may occur on first rising edge after release.
- Enqueue-to-dequeue latency: 1 cycle (enqueued at edge N, deq_valid visible after edge N).
- enq_ready and deq_valid depend only on registered count: no combinational path from enq_* or deq_accept to any output.
- Simultaneous enq and deq: both take effect; count updated by net difference; count never exceeds DEPTH or underflows.
- Full boundary: count=DEPTH−1 → enq_ready=0 even though one entry is free.
- Wrap: tail=DEPTH−1 with n_enq=2 writes entries DEPTH−1 and 0; head=DEPTH−1 presents entries DEPTH−1 and 0 on slots 0/1.
- Flush in the same cycle as reset deassertion or mid-burst: next cycle count=0, deq_valid=0, enq_ready=1.

## Test plan
- Reset then enq_valid=2'b11 pc0=0x1c000000 inst0=0x14000021 pc1=0x1c000004 inst1=0x1c000042, deq_accept=0 → next cycle deq_valid=2'b11, deq_pc0=0x1c000000, deq_inst1=0x1c000042, count=2.
- Fill with 2-wide enqueues, no accepts, DEPTH=8 → after 3 pushes count=6, enq_ready=1; after 4th count=8, enq_ready=0; further enq_valid=2'b11 ignored, count stays 8.
- count=1, deq_accept=2'b11 → only slot0 consumed, count=0, deq_valid=2'b00; count=3, deq_accept=2'b10 → nothing consumed, count=3.
- Steady state count=4, every cycle enq 2 and accept 2 for 10 cycles → count stays 4, pcs exit in exact program order across head/tail wrap (entries 7→0).
- count=5 with enq_valid=2'b11 and deq_accept=2'b11 and flush=1 → next cycle count=0, deq_valid=0, enq_ready=1; following enqueue lands at entry 0.
- Enqueue slot0 with enq_excp0=1 enq_cause0=7'h08 → deq_excp0=1, deq_cause0=7'h08 carried unchanged; assert rst_n low mid-stream → outputs return to reset values immediately without clock edge.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction queue between fetch and decode: up to two entries written per cycle at the tail,
// and the two oldest entries presented at the head; decode consumes zero, one or two per cycle.
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       enq_valid,
    input  logic [31:0]      enq_pc0,
    input  logic [31:0]      enq_pc1,
    input  logic [31:0]      enq_inst0,
    input  logic [31:0]      enq_inst1,
    input  logic             enq_excp0,
    input  logic             enq_excp1,
    input  logic [6:0]       enq_cause0,
    input  logic [6:0]       enq_cause1,
    output logic             enq_ready,
    output logic [1:0]       deq_valid,
    output logic [31:0]      deq_pc0,
    output logic [31:0]      deq_pc1,
    output logic [31:0]      deq_inst0,
    output logic [31:0]      deq_inst1,
    output logic             deq_excp0,
    output logic             deq_excp1,
    output logic [6:0]       deq_cause0,
    output logic [6:0]       deq_cause1,
    input  logic [1:0]       deq_accept,
    output logic [PTR_W:0]   count
);

    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [6:0]  cause;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         n_enq;
    logic [1:0]         n_deq;
    logic [PTR_W-1:0]   head1;
    logic [PTR_W-1:0]   tail1;
    entry_t             enq_e0, enq_e1;
    entry_t             deq_e0, deq_e1;

    // Handshake: a slot transfers when its valid and the opposite side's ready/accept are both high
    // on the same rising edge. enq_ready and deq_valid come only from the registered count, so
    // neither side sees a combinational path from the other; slot1 only moves together with slot0.
    assign enq_ready    = (count_q <= CNT_W'(DEPTH - 2));
    assign deq_valid[0] = (count_q != '0);
    assign deq_valid[1] = (count_q >= CNT_W'(2));
    assign count        = count_q;

    assign head1  = head_q + PTR_W'(1);
    assign tail1  = tail_q + PTR_W'(1);
    assign enq_e0 = '{pc: enq_pc0, inst: enq_inst0, excp: enq_excp0, cause: enq_cause0};
    assign enq_e1 = '{pc: enq_pc1, inst: enq_inst1, excp: enq_excp1, cause: enq_cause1};
    assign deq_e0 = mem_q[head_q];
    assign deq_e1 = mem_q[head1];

    assign deq_pc0    = deq_e0.pc;
    assign deq_inst0  = deq_e0.inst;
    assign deq_excp0  = deq_e0.excp;
    assign deq_cause0 = deq_e0.cause;
    assign deq_pc1    = deq_e1.pc;
    assign deq_inst1  = deq_e1.inst;
    assign deq_excp1  = deq_e1.excp;
    assign deq_cause1 = deq_e1.cause;

    always_comb begin
        n_enq = 2'd0;
        n_deq = 2'd0;
        if (!flush) begin
            if (enq_ready && enq_valid[0]) begin
                n_enq = enq_valid[1] ? 2'd2 : 2'd1;
            end
            if (deq_accept[0] && deq_valid[0]) begin
                n_deq = (deq_accept[1] && deq_valid[1]) ? 2'd2 : 2'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (n_enq != 2'd0) begin
            mem_d[tail_q] = enq_e0;
        end
        if (n_enq == 2'd2) begin
            mem_d[tail1] = enq_e1;
        end

        // Pointers wrap naturally since DEPTH is a power of two.
        head_d  = head_q + PTR_W'(n_deq);
        tail_d  = tail_q + PTR_W'(n_enq);
        count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized plus directed bench for inst_buffer, checked every cycle against an in-order queue model.
module tb_inst_buffer;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [6:0]  cause;
    } ent_t;

    // clock / reset block
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush;
    logic [1:0]  enq_valid;
    logic [31:0] enq_pc0, enq_pc1, enq_inst0, enq_inst1;
    logic        enq_excp0, enq_excp1;
    logic [6:0]  enq_cause0, enq_cause1;
    logic        enq_ready;
    logic [1:0]  deq_valid;
    logic [31:0] deq_pc0, deq_pc1, deq_inst0, deq_inst1;
    logic        deq_excp0, deq_excp1;
    logic [6:0]  deq_cause0, deq_cause1;
    logic [1:0]  deq_accept;
    logic [3:0]  count;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid),
        .enq_pc0(enq_pc0), .enq_pc1(enq_pc1),
        .enq_inst0(enq_inst0), .enq_inst1(enq_inst1),
        .enq_excp0(enq_excp0), .enq_excp1(enq_excp1),
        .enq_cause0(enq_cause0), .enq_cause1(enq_cause1),
        .enq_ready(enq_ready), .deq_valid(deq_valid),
        .deq_pc0(deq_pc0), .deq_pc1(deq_pc1),
        .deq_inst0(deq_inst0), .deq_inst1(deq_inst1),
        .deq_excp0(deq_excp0), .deq_excp1(deq_excp1),
        .deq_cause0(deq_cause0), .deq_cause1(deq_cause1),
        .deq_accept(deq_accept), .count(count)
    );

    // scoreboard: expected queue contents in program order
    ent_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          check_en = 1'b0;
    logic [31:0] pc_ctr = 32'h1c00_1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: outputs are stable mid-cycle
    always @(negedge clk) begin
        if (check_en) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("enq_ready", 32'(enq_ready), 32'((DEPTH - exp_q.size()) >= 2));
            chk("deq_valid", 32'(deq_valid), 32'({exp_q.size() >= 2, exp_q.size() >= 1}));
            if (exp_q.size() >= 1) begin
                chk("deq_pc0", deq_pc0, exp_q[0].pc);
                chk("deq_inst0", deq_inst0, exp_q[0].inst);
                chk("deq_excp0", 32'(deq_excp0), 32'(exp_q[0].excp));
                chk("deq_cause0", 32'(deq_cause0), 32'(exp_q[0].cause));
            end
            if (exp_q.size() >= 2) begin
                chk("deq_pc1", deq_pc1, exp_q[1].pc);
                chk("deq_inst1", deq_inst1, exp_q[1].inst);
                chk("deq_excp1", 32'(deq_excp1), 32'(exp_q[1].excp));
                chk("deq_cause1", 32'(deq_cause1), 32'(exp_q[1].cause));
            end
        end
    end

    function automatic ent_t rand_ent();
        ent_t e;
        e.pc    = pc_ctr;
        pc_ctr  = pc_ctr + 32'd4;
        e.inst  = $urandom;
        e.excp  = ($urandom_range(0, 7) == 0);
        e.cause = 7'($urandom_range(0, 127));
        return e;
    endfunction

    // driver: apply one cycle of inputs, then advance the model across the edge
    task automatic step(input logic [1:0] ev, input logic [1:0] acc, input logic fl,
                        input ent_t e0, input ent_t e1);
        int sz;
        int ne;
        int nd;
        flush      = fl;
        enq_valid  = ev;
        deq_accept = acc;
        enq_pc0 = e0.pc;     enq_inst0 = e0.inst; enq_excp0 = e0.excp; enq_cause0 = e0.cause;
        enq_pc1 = e1.pc;     enq_inst1 = e1.inst; enq_excp1 = e1.excp; enq_cause1 = e1.cause;
        sz = exp_q.size();
        ne = ((DEPTH - sz) >= 2 && ev[0]) ? (ev[1] ? 2 : 1) : 0;
        nd = (acc[0] && sz >= 1) ? ((acc[1] && sz >= 2) ? 2 : 1) : 0;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            repeat (nd) void'(exp_q.pop_front());
            if (ne >= 1) exp_q.push_back(e0);
            if (ne == 2) exp_q.push_back(e1);
        end
    endtask

    task automatic rstep(input logic [1:0] ev, input logic [1:0] acc, input logic fl);
        ent_t a;
        ent_t b;
        a = rand_ent();
        b = rand_ent();
        step(ev, acc, fl, a, b);
    endtask

    task automatic random_cycles(input int n);
        logic [1:0] ev;
        for (int i = 0; i < n; i++) begin
            ev = 2'($urandom_range(0, 3));
            rstep(ev, 2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_deq_valid"}, 32'(deq_valid), 32'd0);
        chk({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
        chk({tag, "_deq_pc0"}, deq_pc0, 32'd0);
        chk({tag, "_deq_inst1"}, deq_inst1, 32'd0);
        chk({tag, "_deq_excp0"}, 32'(deq_excp0), 32'd0);
        chk({tag, "_deq_cause0"}, 32'(deq_cause0), 32'd0);
    endtask

    initial begin
        ent_t d0;
        ent_t d1;
        flush = 1'b0; enq_valid = 2'b00; deq_accept = 2'b00;
        enq_pc0 = '0; enq_pc1 = '0; enq_inst0 = '0; enq_inst1 = '0;
        enq_excp0 = 1'b0; enq_excp1 = 1'b0; enq_cause0 = '0; enq_cause1 = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n    = 1'b1;
        check_en = 1'b1;

        // flush on the first cycle after reset release dominates the enqueue
        rstep(2'b11, 2'b00, 1'b1);
        chk("flush_at_release_count", 32'(count), 32'd0);

        // first dual enqueue
        d0 = '{pc: 32'h1c00_0000, inst: 32'h1400_0021, excp: 1'b0, cause: 7'h00};
        d1 = '{pc: 32'h1c00_0004, inst: 32'h1c00_0042, excp: 1'b0, cause: 7'h00};
        step(2'b11, 2'b00, 1'b0, d0, d1);
        chk("first_deq_valid", 32'(deq_valid), 32'h3);
        chk("first_pc0", deq_pc0, 32'h1c00_0000);
        chk("first_pc1", deq_pc1, 32'h1c00_0004);
        chk("first_inst1", deq_inst1, 32'h1c00_0042);
        chk("first_count", 32'(count), 32'd2);

        // fill to the full boundary
        rstep(2'b00, 2'b00, 1'b1);
        repeat (3) rstep(2'b11, 2'b00, 1'b0);
        chk("fill6_count", 32'(count), 32'd6);
        chk("fill6_ready", 32'(enq_ready), 32'd1);
        rstep(2'b11, 2'b00, 1'b0);
        chk("fill8_count", 32'(count), 32'd8);
        chk("fill8_ready", 32'(enq_ready), 32'd0);
        rstep(2'b11, 2'b00, 1'b0);
        chk("full_ignore_count", 32'(count), 32'd8);

        // accept masking
        repeat (3) rstep(2'b00, 2'b11, 1'b0);
        rstep(2'b00, 2'b01, 1'b0);
        chk("drain_count1", 32'(count), 32'd1);
        rstep(2'b00, 2'b11, 1'b0);
        chk("acc11_at1_count", 32'(count), 32'd0);
        chk("acc11_at1_valid", 32'(deq_valid), 32'd0);
        rstep(2'b11, 2'b00, 1'b0);
        rstep(2'b01, 2'b00, 1'b0);
        rstep(2'b10, 2'b00, 1'b0);
        chk("enq10_ignored_count", 32'(count), 32'd3);
        rstep(2'b00, 2'b10, 1'b0);
        chk("acc10_count", 32'(count), 32'd3);

        // steady state through many wraps
        rstep(2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rstep(2'b11, 2'b11, 1'b0);
            chk("steady_count", 32'(count), 32'd4);
        end

        // flush dominates simultaneous enqueue and dequeue
        rstep(2'b01, 2'b00, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd5);
        rstep(2'b11, 2'b11, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(deq_valid), 32'd0);
        chk("flush_ready", 32'(enq_ready), 32'd1);
        d0 = rand_ent();
        step(2'b01, 2'b00, 1'b0, d0, rand_ent());
        chk("post_flush_pc0", deq_pc0, d0.pc);

        // fetch exception fields carried through
        rstep(2'b00, 2'b00, 1'b1);
        d0 = '{pc: 32'h1c00_0100, inst: 32'h0000_0000, excp: 1'b1, cause: 7'h08};
        step(2'b01, 2'b00, 1'b0, d0, rand_ent());
        chk("excp0", 32'(deq_excp0), 32'd1);
        chk("cause0", 32'(deq_cause0), 32'h08);

        random_cycles(600);

        // asynchronous reset mid-stream, observed before any clock edge
        rstep(2'b11, 2'b00, 1'b0);
        #2;
        rst_n    = 1'b0;
        check_en = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        check_en = 1'b1;

        random_cycles(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
